adc_cap_ctrl: RTL

ADC_CAP_CTRL -- requirements
Module: adc_cap_ctrl

---
 rtl/adc_cap_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/adc_cap_ctrl.sv
// adc_cap_ctrl: triggered ADC capture controller feeding a 2^ADDR_W-deep sample RAM write port.
// Latency: adc_data reaches wr_data two cycles later; an accepted trigger writes its sample the next cycle.
// No backpressure (RAM takes one write per cycle); define ADC_CAP_PRETRIG_EN for circular pre-trigger capture.
module adc_cap_ctrl #(
   parameter int ADDR_W = 10,
   parameter int PRE    = 256
) (
   input  logic              clk_adc,
   input  logic              rst_n,
   input  logic [9:0]        adc_data,
   input  logic              arm,
   input  logic              abort,
   input  logic              force_trig,
   input  logic [9:0]        thresh,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [9:0]        wr_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] trig_addr
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

   localparam logic [ADDR_W:0] N_C = {1'b1, {ADDR_W{1'b0}}};
`ifdef ADC_CAP_PRETRIG_EN
   // Pre-trigger samples already sit in the buffer, so only the remainder is captured after the trigger.
   localparam logic [ADDR_W:0] PRE_C  = (ADDR_W+1)'(PRE);
   localparam logic [ADDR_W:0] POST_C = N_C - PRE_C;
`else
   localparam logic [ADDR_W:0] POST_C = N_C;
   // PRE only matters for pre-trigger capture.
   logic unused_pre;
   assign unused_pre = (PRE != 0);
`endif

   state_t            state_q, state_d;
   logic [9:0]        d1_q, d1_d, d2_q, d2_d, wr_data_q, wr_data_d;
   logic              wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, trig_addr_q, trig_addr_d, ptr_q, ptr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              trig;

   // Trigger on an upward crossing of thresh between the two delayed samples, or on software request.
   always_comb begin
      trig = (($signed(d2_q) < $signed(thresh)) && ($signed(d1_q) >= $signed(thresh))) || force_trig;
   end

   // Next-state, write-port and counter logic; abort overrides everything else.
   always_comb begin
      state_d     = state_q;
      d1_d        = adc_data;
      d2_d        = d1_q;
      wr_data_d   = d1_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      trig_addr_d = trig_addr_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (arm) begin
               state_d   = S_ARMED;
               ptr_d     = '0;
               wr_addr_d = '0;
               cnt_d     = '0;
            end
         end
         S_ARMED: begin
`ifdef ADC_CAP_PRETRIG_EN
            // Keep filling the ring; a trigger counts only once PRE samples of history exist.
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            ptr_d     = ptr_q + 1'b1;
            if (trig && (cnt_q >= PRE_C)) begin
               state_d     = S_CAPTURE;
               trig_addr_d = ptr_q;
               cnt_d       = (ADDR_W+1)'(1);
            end else if (cnt_q < PRE_C) begin
               cnt_d = cnt_q + 1'b1;
            end
`else
            if (trig) begin
               state_d     = S_CAPTURE;
               wr_en_d     = 1'b1;
               wr_addr_d   = ptr_q;
               ptr_d       = ptr_q + 1'b1;
               trig_addr_d = '0;
               cnt_d       = (ADDR_W+1)'(1);
            end
`endif
         end
         S_CAPTURE: begin
            // cnt_q counts writes already issued, trigger sample included.
            if (cnt_q == POST_C) begin
               state_d = S_DONE;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = ptr_q;
               ptr_d     = ptr_q + 1'b1;
               cnt_d     = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d = S_IDLE;
         wr_en_d = 1'b0;
      end
      busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_adc) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         d1_q        <= '0;
         d2_q        <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         trig_addr_q <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         d1_q        <= d1_d;
         d2_q        <= d2_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         trig_addr_q <= trig_addr_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign trig_addr = trig_addr_q;

endmodule
